// File: rtl/if_id_buffer.sv
// if_id_buffer
//   Decoupling FIFO between instruction fetch and decode. Each accepted
//   {pc, instruction} pair is queued and the oldest entry is presented to
//   decode with a valid/ready handshake. A flush (taken branch) discards
//   everything queued plus the entry being offered, and the number of
//   discarded entries accumulates in a saturating counter.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   if_valid   fetch offers if_pc/if_instr this cycle
//   if_pc      pc of the offered instruction
//   if_instr   offered instruction word
//   if_ready   buffer has room (registered count only)
//   id_valid   head entry valid for decode
//   id_pc      pc of the head entry (0 when empty)
//   id_instr   instruction of the head entry (0 when empty)
//   id_ready   decode consumes the head entry this cycle
//   flush      discard all buffered and incoming entries
//   occupancy  number of valid entries
//   drop_cnt   saturating count of entries discarded by flush

module if_id_buffer #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [WIDTH-1:0]           if_pc,
  input  logic [WIDTH-1:0]           if_instr,
  output logic                       if_ready,
  output logic                       id_valid,
  output logic [WIDTH-1:0]           id_pc,
  output logic [WIDTH-1:0]           id_instr,
  input  logic                       id_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNTW-1:0]            drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Wide enough that drop_cnt + count + 1 never overflows before saturation.
  localparam int SW = CNTW + CW + 1;

  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0]   DROP_MAX = SW'({CNTW{1'b1}});

  logic [WIDTH-1:0] mem_pc    [DEPTH];
  logic [WIDTH-1:0] mem_instr [DEPTH];

  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;
  logic [SW-1:0] drop_sum;

  assign if_ready  = (count < DEPTH_C);
  assign id_valid  = (count != '0);
  assign occupancy = count;

  assign push = if_valid & if_ready & ~flush;
  assign pop  = id_valid & id_ready & ~flush;

  assign id_pc    = id_valid ? mem_pc[rptr]    : '0;
  assign id_instr = id_valid ? mem_instr[rptr] : '0;

  // The offered entry counts as dropped whether or not there was room for it.
  assign drop_sum = SW'(drop_cnt) + SW'(count) + SW'(if_valid);

  // Storage needs no reset; id_* are masked by id_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wptr]    <= if_pc;
      mem_instr[wptr] <= if_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      drop_cnt <= (drop_sum > DROP_MAX) ? {CNTW{1'b1}} : drop_sum[CNTW-1:0];
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  localparam int WIDTH = 19;
  localparam int DEPTH = 2;
  localparam int CNTW  = 8;

  logic             clk;
  logic             rst;
  logic             if_valid;
  logic [WIDTH-1:0] if_pc;
  logic [WIDTH-1:0] if_instr;
  logic             if_ready;
  logic             id_valid;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_instr;
  logic             id_ready;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNTW-1:0]  drop_cnt;

  int vectors;
  int miscompares;
  int exp_drop;

  if_id_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
    .flush(flush), .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] instr_of(input logic [WIDTH-1:0] pc);
    return pc ^ 19'h5A5A5;
  endfunction

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input int pc);
    if_valid = v;
    if_pc    = WIDTH'(pc);
    if_instr = instr_of(WIDTH'(pc));
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; id_ready = 1'b0;
    offer(1'b0, 0);
    #12;
    vectors++;
    if (occupancy !== 2'd0 || id_valid !== 1'b0 || if_ready !== 1'b1 ||
        id_pc !== '0 || id_instr !== '0 || drop_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset: occ=%0d id_valid=%b if_ready=%b id_pc=%0d id_instr=%0h drop=%0d, want 0 0 1 0 0 0",
               occupancy, id_valid, if_ready, id_pc, id_instr, drop_cnt);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_fill();
    tick();
    offer(1'b1, 0);
    tick();
    vectors++;
    if (occupancy !== 2'd1 || id_pc !== 19'd0 || if_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_first: occ=%0d id_pc=%0d if_ready=%b, want 1 0 1", occupancy, id_pc, if_ready);
    end
    offer(1'b1, 1);
    tick();
    vectors++;
    if (occupancy !== 2'd2 || if_ready !== 1'b0 || id_pc !== 19'd0 || id_instr !== instr_of(19'd0)) begin
      miscompares++;
      $display("FAIL fill_full: occ=%0d if_ready=%b id_pc=%0d id_instr=%0h, want 2 0 0 %0h",
               occupancy, if_ready, id_pc, id_instr, instr_of(19'd0));
    end
    offer(1'b1, 2);
    tick();
    vectors++;
    if (occupancy !== 2'd2 || id_pc !== 19'd0 || if_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_hold: occ=%0d id_pc=%0d if_ready=%b, want 2 0 0", occupancy, id_pc, if_ready);
    end
  endtask

  task automatic test_drain_push();
    id_ready = 1'b1;
    tick();
    vectors++;
    if (occupancy !== 2'd1 || id_pc !== 19'd1 || id_instr !== instr_of(19'd1) || if_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_pop_only: occ=%0d id_pc=%0d id_instr=%0h if_ready=%b, want 1 1 %0h 1",
               occupancy, id_pc, id_instr, if_ready, instr_of(19'd1));
    end
    tick();
    vectors++;
    if (occupancy !== 2'd1 || id_pc !== 19'd2 || id_instr !== instr_of(19'd2)) begin
      miscompares++;
      $display("FAIL drain_push_pop: occ=%0d id_pc=%0d id_instr=%0h, want 1 2 %0h",
               occupancy, id_pc, id_instr, instr_of(19'd2));
    end
    id_ready = 1'b0;
    offer(1'b1, 3);
    tick();
    vectors++;
    if (occupancy !== 2'd2 || id_pc !== 19'd2) begin
      miscompares++;
      $display("FAIL drain_refill: occ=%0d id_pc=%0d, want 2 2", occupancy, id_pc);
    end
  endtask

  task automatic test_flush();
    offer(1'b1, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (occupancy !== 2'd0 || id_valid !== 1'b0 || drop_cnt !== 8'd3 || if_ready !== 1'b1 || id_pc !== '0) begin
      miscompares++;
      $display("FAIL flush: occ=%0d id_valid=%b drop=%0d if_ready=%b id_pc=%0d, want 0 0 3 1 0",
               occupancy, id_valid, drop_cnt, if_ready, id_pc);
    end
    offer(1'b1, 138);
    tick();
    vectors++;
    if (occupancy !== 2'd1 || id_pc !== 19'd138 || id_instr !== instr_of(19'd138)) begin
      miscompares++;
      $display("FAIL flush_target: occ=%0d id_pc=%0d id_instr=%0h, want 1 138 %0h",
               occupancy, id_pc, id_instr, instr_of(19'd138));
    end
    exp_drop = 3;
  endtask

  task automatic test_wrap();
    offer(1'b0, 0);
    id_ready = 1'b1;
    tick();
    vectors++;
    if (occupancy !== 2'd0 || id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_empty: occ=%0d id_valid=%b, want 0 0", occupancy, id_valid);
    end
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, i);
      tick();
      vectors++;
      if (id_pc !== WIDTH'(i) || occupancy !== 2'd1 || id_instr !== instr_of(WIDTH'(i))) begin
        miscompares++;
        $display("FAIL wrap_stream[%0d]: id_pc=%0d occ=%0d, want %0d 1", i, id_pc, occupancy, i);
      end
    end
    offer(1'b0, 0);
    tick();
    id_ready = 1'b0;
    vectors++;
    if (occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_drain: occ=%0d, want 0", occupancy);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 90; k++) begin
      offer(1'b1, 2 * k);
      tick();
      offer(1'b1, 2 * k + 1);
      tick();
      offer(1'b1, 999);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_drop = (exp_drop + 3 > 255) ? 255 : exp_drop + 3;
      vectors++;
      if (drop_cnt !== CNTW'(exp_drop) || occupancy !== 2'd0) begin
        miscompares++;
        $display("FAIL saturation[%0d]: drop=%0d occ=%0d, want %0d 0", k, drop_cnt, occupancy, exp_drop);
      end
    end
    vectors++;
    if (drop_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation_final: drop=%0d, want 255", drop_cnt);
    end
    offer(1'b0, 0);
  endtask

  task automatic test_async_reset();
    offer(1'b1, 40);
    tick();
    offer(1'b1, 41);
    tick();
    offer(1'b0, 0);
    vectors++;
    if (occupancy !== 2'd2) begin
      miscompares++;
      $display("FAIL async_setup: occ=%0d, want 2", occupancy);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (id_valid !== 1'b0 || occupancy !== 2'd0 || drop_cnt !== 8'd0 || if_ready !== 1'b1 || id_pc !== '0) begin
      miscompares++;
      $display("FAIL async_reset: id_valid=%b occ=%0d drop=%0d if_ready=%b id_pc=%0d, want 0 0 0 1 0",
               id_valid, occupancy, drop_cnt, if_ready, id_pc);
    end
    #10 rst = 1'b1;
    offer(1'b1, 77);
    tick();
    vectors++;
    if (occupancy !== 2'd1 || id_pc !== 19'd77) begin
      miscompares++;
      $display("FAIL after_reset: occ=%0d id_pc=%0d, want 1 77", occupancy, id_pc);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_drop = 0;
    test_reset();
    test_fill();
    test_drain_push();
    test_flush();
    test_wrap();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
